dma_priority_resolver: RTL and testbench

Priority resolver stage of the 8237A-style DMA controller. It consumes the command, request and mask registers, reads the four external DREQ lines and picks one channel under fixed or rotating priority. It then runs the HRQ/HLDA bus handshake and drives DACK. Downstream, the timing-control block receives the granted channel and signals end of service back to this block.

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_prio_picker.sv | 25 ++
 rtl/dma_priority_resolver.sv | 108 ++++++++++
 tb/tb_dma_priority_resolver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA priority resolver
package dma_pkg;

  localparam int NCH = 4;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT
  } prState_t;

  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    onehot4 = 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_prio_picker.sv
// rtl/dma_prio_picker.sv - combinational picker; scans hi, hi+1, hi+2, hi+3 (mod 4)
module dma_prio_picker (
  input  logic [3:0] req,
  input  logic [1:0] hi,
  output logic       found,
  output logic [1:0] ch
);

  logic [1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    found = 1'b0;
    ch    = hi;
    idx   = hi;
    for (int i = 3; i >= 0; i--) begin
      idx = hi + 2'(i);
      if (req[idx]) begin
        found = 1'b1;
        ch    = idx;
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// rtl/dma_priority_resolver.sv - 8237A-style channel arbitration and HRQ/HLDA/DACK handshake
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     commandReg,
  input  logic [7:0]     requestReg,
  input  logic [7:0]     maskReg,
  input  logic           HLDA,
  input  logic           svcDone,
  output logic           HRQ,
  output logic [NCH-1:0] DACK,
  output logic           grantValid,
  output logic [1:0]     grantCh,
  output logic [NCH-1:0] swReqClr
);

  prState_t state, state_nxt;

  logic [NCH-1:0] dreq_q;
  logic [NCH-1:0] sreq;
  logic [NCH-1:0] ereq;
  logic [NCH-1:0] dack_int;
  logic [1:0]     hi;
  logic [1:0]     hi_eff;
  logic [1:0]     win_ch;
  logic           win_found;
  logic           take_grant;
  logic           svc_end;
  logic           disabled;

  assign sreq     = dreq_q ^ {NCH{commandReg[CMD_DREQ_LOW]}};
  assign ereq     = (sreq & ~maskReg[NCH-1:0]) | requestReg[NCH-1:0];
  assign hi_eff   = commandReg[CMD_ROTATE] ? hi : 2'd0;
  assign disabled = commandReg[CMD_DISABLE];

  dma_prio_picker u_picker (
    .req   (ereq),
    .hi    (hi_eff),
    .found (win_found),
    .ch    (win_ch)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // svcDone takes precedence over an HLDA drop in the same cycle.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    svc_end    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && !disabled) state_nxt = REQ;
      end
      REQ: begin
        if (!win_found || disabled) begin
          state_nxt = IDLE;
        end else if (HLDA) begin
          state_nxt  = GRANT;
          take_grant = 1'b1;
        end
      end
      GRANT: begin
        if (svcDone) begin
          state_nxt = IDLE;
          svc_end   = 1'b1;
        end else if (!HLDA) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_q   <= '0;
      hi       <= 2'd0;
      grantCh  <= 2'd0;
      swReqClr <= '0;
    end else begin
      dreq_q <= DREQ;
      if (take_grant) grantCh <= win_ch;
      if (svc_end) hi <= grantCh + 2'd1;
      swReqClr <= (svc_end && requestReg[grantCh]) ? onehot4(grantCh) : '0;
    end
  end

  assign HRQ        = (state != IDLE);
  assign grantValid = (state == GRANT);
  assign dack_int   = grantValid ? onehot4(grantCh) : '0;
  assign DACK       = dack_int ^ {NCH{~commandReg[CMD_DACK_HIGH]}};

  logic unused_cfg;
  assign unused_cfg = ^{commandReg[5], commandReg[3], commandReg[1:0],
                        requestReg[7:4], maskReg[7:4]};

endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb/tb_dma_priority_resolver.sv - directed vectors and corner sequences for dma_priority_resolver
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = 4'h0;
  logic [7:0] commandReg = 8'h00;
  logic [7:0] requestReg = 8'h00;
  logic [7:0] maskReg = 8'h00;
  logic       HLDA = 1'b0;
  logic       svcDone = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantCh;
  logic [3:0] swReqClr;

  int n_checks = 0;
  int n_fail = 0;

  dma_priority_resolver #(.NCH(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DREQ       (DREQ),
    .commandReg (commandReg),
    .requestReg (requestReg),
    .maskReg    (maskReg),
    .HLDA       (HLDA),
    .svcDone    (svcDone),
    .HRQ        (HRQ),
    .DACK       (DACK),
    .grantValid (grantValid),
    .grantCh    (grantCh),
    .swReqClr   (swReqClr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] dreq;
    logic [3:0] req;
    logic [3:0] mask;
    logic       hrq;
    logic [1:0] ch;
    logic [3:0] dack;
    logic [3:0] clr;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    HLDA = 1'b0;
    svcDone = 1'b0;
    step();
    RESET = 1'b0;
  endtask

  task automatic wait_hrq(input string name);
    int n = 0;
    while (!HRQ && n < 8) begin
      step();
      n++;
    end
    check({name, " hrq"}, {7'd0, HRQ}, 8'd1);
  endtask

  // Wait for HRQ, grant, check the winning channel, then complete service.
  task automatic grant_and_release(input string name, input logic [1:0] exp_ch);
    wait_hrq(name);
    HLDA = 1'b1;
    step();
    check({name, " ch"}, {6'd0, grantCh}, {6'd0, exp_ch});
    svcDone = 1'b1;
    HLDA = 1'b0;
    step();
    svcDone = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h00, 4'b0101, 4'h0, 4'h0, 1'b1, 2'd0, 4'b1110, 4'h0};
    vecs[1] = '{8'h40, 4'b0101, 4'h0, 4'h0, 1'b1, 2'd1, 4'b1101, 4'h0};
    vecs[2] = '{8'h80, 4'b1100, 4'h0, 4'h0, 1'b1, 2'd2, 4'b0100, 4'h0};
    vecs[3] = '{8'h00, 4'b1111, 4'h0, 4'h7, 1'b1, 2'd3, 4'b0111, 4'h0};
    vecs[4] = '{8'h00, 4'b0000, 4'h4, 4'hF, 1'b1, 2'd2, 4'b1011, 4'h4};
    vecs[5] = '{8'h00, 4'b0001, 4'h8, 4'h1, 1'b1, 2'd3, 4'b0111, 4'h8};
    vecs[6] = '{8'h84, 4'b1111, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0,    4'h0};
    vecs[7] = '{8'h00, 4'b1111, 4'h0, 4'hF, 1'b0, 2'd0, 4'hF,    4'h0};

    do_reset();
    check("reset hrq", {7'd0, HRQ}, 8'd0);
    check("reset grantValid", {7'd0, grantValid}, 8'd0);
    check("reset grantCh", {6'd0, grantCh}, 8'd0);
    check("reset dack", {4'd0, DACK}, 8'h0F);
    check("reset swReqClr", {4'd0, swReqClr}, 8'd0);

    for (int i = 0; i < 8; i++) begin
      commandReg = vecs[i].cmd;
      DREQ = vecs[i].dreq;
      requestReg = {4'd0, vecs[i].req};
      maskReg = {4'd0, vecs[i].mask};
      do_reset();
      if (vecs[i].hrq) begin
        wait_hrq($sformatf("vec%0d", i));
        HLDA = 1'b1;
        step();
        check($sformatf("vec%0d grantValid", i), {7'd0, grantValid}, 8'd1);
        check($sformatf("vec%0d ch", i), {6'd0, grantCh}, {6'd0, vecs[i].ch});
        check($sformatf("vec%0d dack", i), {4'd0, DACK}, {4'd0, vecs[i].dack});
        svcDone = 1'b1;
        step();
        svcDone = 1'b0;
        HLDA = 1'b0;
        check($sformatf("vec%0d clr", i), {4'd0, swReqClr}, {4'd0, vecs[i].clr});
        check($sformatf("vec%0d hrq off", i), {7'd0, HRQ}, 8'd0);
        requestReg = 8'h00;
        step();
        check($sformatf("vec%0d clr pulse", i), {4'd0, swReqClr}, 8'd0);
      end else begin
        repeat (6) step();
        check($sformatf("vec%0d no hrq", i), {7'd0, HRQ}, 8'd0);
      end
    end

    // Fixed priority, active-low DREQ, late HLDA, then ch3 after ch1 is released.
    commandReg = 8'h40; DREQ = 4'b0101; requestReg = 8'h00; maskReg = 8'h00;
    do_reset();
    wait_hrq("fixed1");
    repeat (2) step();
    HLDA = 1'b1;
    step();
    check("fixed1 ch", {6'd0, grantCh}, 8'd1);
    check("fixed1 dack", {4'd0, DACK}, 8'h0D);
    DREQ = 4'b0111;
    svcDone = 1'b1;
    HLDA = 1'b0;
    step();
    svcDone = 1'b0;
    check("fixed1 release", {7'd0, grantValid}, 8'd0);
    grant_and_release("fixed2", 2'd3);

    // Rotating priority with all channels requesting.
    commandReg = 8'h10; DREQ = 4'hF;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      grant_and_release($sformatf("rot%0d", i), 2'(i % 4));
    end

    // Pre-emption: ch0 arrives while ch3 waits for HLDA.
    commandReg = 8'h00; DREQ = 4'b1000;
    do_reset();
    wait_hrq("preempt");
    DREQ = 4'b1001;
    step();
    HLDA = 1'b1;
    step();
    check("preempt ch", {6'd0, grantCh}, 8'd0);
    HLDA = 1'b0;
    step();
    check("preempt abort", {7'd0, grantValid}, 8'd0);

    // Abort keeps the old rotation pointer.
    commandReg = 8'h10; DREQ = 4'hF;
    do_reset();
    grant_and_release("abort0", 2'd0);
    wait_hrq("abort1");
    HLDA = 1'b1;
    step();
    check("abort1 ch", {6'd0, grantCh}, 8'd1);
    HLDA = 1'b0;
    step();
    check("abort1 hrq", {7'd0, HRQ}, 8'd0);
    check("abort1 clr", {4'd0, swReqClr}, 8'd0);
    grant_and_release("abort2", 2'd1);

    // Disable while in REQ.
    commandReg = 8'h00; DREQ = 4'b0001;
    do_reset();
    wait_hrq("disable");
    commandReg = 8'h04;
    step();
    check("disable hrq", {7'd0, HRQ}, 8'd0);

    // Reset mid-GRANT, coincident with svcDone.
    commandReg = 8'h00; DREQ = 4'h0; requestReg = 8'h04; maskReg = 8'h00;
    do_reset();
    wait_hrq("rstgrant");
    HLDA = 1'b1;
    step();
    check("rstgrant ch", {6'd0, grantCh}, 8'd2);
    RESET = 1'b1;
    svcDone = 1'b1;
    step();
    RESET = 1'b0;
    svcDone = 1'b0;
    HLDA = 1'b0;
    requestReg = 8'h00;
    check("rstgrant hrq", {7'd0, HRQ}, 8'd0);
    check("rstgrant grantValid", {7'd0, grantValid}, 8'd0);
    check("rstgrant grantCh", {6'd0, grantCh}, 8'd0);
    check("rstgrant dack", {4'd0, DACK}, 8'h0F);
    check("rstgrant clr", {4'd0, swReqClr}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
